// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and helpers for the single-port SRAM arbiter
package sram_arb_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD_ADDR = 2'd2,
        RD_DATA = 2'd3
    } state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_sp_arbiter_if.sv
// rtl/sram_sp_arbiter_if.sv - requester-side command/response bundle of sram_sp_arbiter
interface sram_sp_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REQ    = 2
);
    logic [NUM_REQ-1:0]            req_i;
    logic [NUM_REQ-1:0]            we_i;
    logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i;
    logic [NUM_REQ-1:0]            gnt_o;
    logic [NUM_REQ-1:0]            rvalid_o;
    logic [DATA_WIDTH-1:0]         rdata_o;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o
    );
endinterface

// File: rtl/sram_arb_pick.sv
// rtl/sram_arb_pick.sv - combinational winner select; SRAM_ARB_RR_EN selects round-robin, else fixed priority
module sram_arb_pick
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
`ifdef SRAM_ARB_RR_EN
    input  logic [IDX_W-1:0]   ptr_i,
`endif
    output logic               valid_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic [NUM_REQ-1:0] gnt_o
);

`ifdef SRAM_ARB_RR_EN
    logic [2*NUM_REQ-1:0] rot;
    logic [IDX_W-1:0]     off;
    logic [IDX_W:0]       sum;

    // Rotate so the pointer position sits at bit 0, take the lowest set bit, then un-rotate.
    always_comb begin
        valid_o = 1'b0;
        off     = '0;
        rot     = {req_i, req_i} >> ptr_i;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                valid_o = 1'b1;
                off     = IDX_W'(k);
            end
        end
        sum   = {1'b0, ptr_i} + {1'b0, off};
        idx_o = (sum >= (IDX_W + 1)'(NUM_REQ)) ? IDX_W'(sum - (IDX_W + 1)'(NUM_REQ))
                                               : sum[IDX_W-1:0];
    end
`else
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'(k);
            end
        end
    end
`endif

    assign gnt_o = valid_o ? (NUM_REQ'(1) << idx_o) : '0;

endmodule

// File: rtl/sram_sp_arbiter.sv
// rtl/sram_sp_arbiter.sv - shares one single-port SRAM among NUM_REQ requesters; SRAM_ARB_RR_EN enables round-robin
module sram_sp_arbiter
    import sram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REQ    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sram_sp_arbiter_if.slave      bus,
    output logic                  sram_cs,
    output logic                  sram_we,
    output logic                  sram_oe,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    inout  wire  [DATA_WIDTH-1:0] sram_data
);

    localparam int IDX_W = idx_width(NUM_REQ);

    state_e                state_q, state_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic [NUM_REQ-1:0]    rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [IDX_W-1:0]      owner_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  load;

    logic                  pick_valid;
    logic [IDX_W-1:0]      pick_idx;
    logic [NUM_REQ-1:0]    pick_gnt;

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            addr_arr[k]  = bus.addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_arr[k] = bus.wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

`ifdef SRAM_ARB_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    assign ptr_d = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;

    sram_arb_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req_i   (bus.req_i),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx),
        .gnt_o   (pick_gnt)
    );
`else
    sram_arb_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req_i   (bus.req_i),
        .valid_o (pick_valid),
        .idx_o   (pick_idx),
        .gnt_o   (pick_gnt)
    );
`endif

    always_comb begin
        state_d  = state_q;
        gnt_d    = '0;
        rvalid_d = '0;
        rdata_d  = rdata_q;
        load     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    load    = 1'b1;
                    gnt_d   = pick_gnt;
                    state_d = bus.we_i[pick_idx] ? WR : RD_ADDR;
                end
            end
            WR:      state_d = IDLE;
            RD_ADDR: state_d = RD_DATA;
            RD_DATA: begin
                state_d  = IDLE;
                rdata_d  = sram_data;
                rvalid_d = NUM_REQ'(1) << owner_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            owner_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
`ifdef SRAM_ARB_RR_EN
            ptr_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            if (load) begin
                owner_q <= pick_idx;
                addr_q  <= addr_arr[pick_idx];
                wdata_q <= wdata_arr[pick_idx];
`ifdef SRAM_ARB_RR_EN
                ptr_q   <= ptr_d;
`endif
            end
        end
    end

    // Pins decode straight from the registered state, so oe and we can never overlap.
    always_comb begin
        sram_cs   = (state_q != IDLE);
        sram_we   = (state_q == WR);
        sram_oe   = (state_q == RD_ADDR) || (state_q == RD_DATA);
        sram_addr = sram_cs ? addr_q : '0;
    end

    assign sram_data    = (state_q == WR) ? wdata_q : 'z;
    assign bus.gnt_o    = gnt_q;
    assign bus.rvalid_o = rvalid_q;
    assign bus.rdata_o  = rdata_q;

endmodule

// File: tb/tb_sram_sp_arbiter.sv
// tb/tb_sram_sp_arbiter.sv - scoreboard bench for sram_sp_arbiter with behavioural SRAM model
module tb_sram_sp_arbiter;

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } cmd_t;

    typedef struct {
        int         id;
        logic [7:0] data;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sram_cs, sram_we, sram_oe;
    logic [7:0] sram_addr;
    wire  [7:0] sram_data;

    sram_sp_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .NUM_REQ(2)) bus ();

    sram_sp_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .NUM_REQ(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .sram_cs   (sram_cs),
        .sram_we   (sram_we),
        .sram_oe   (sram_oe),
        .sram_addr (sram_addr),
        .sram_data (sram_data)
    );

    always #5 clk = ~clk;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    logic [7:0] dout_q;

    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_we) mem[sram_addr] <= sram_data;
            else if (sram_oe) dout_q <= mem[sram_addr];
        end
    end
    assign sram_data = (sram_cs && sram_oe && !sram_we) ? dout_q : 8'bz;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    cmd_t q0[$];
    cmd_t q1[$];
    exp_t sb[$];
    int   glog_id[$];
    int   glog_cyc[$];
    cmd_t cur      [2];
    bit   act      [2];
    int   pres_cyc [2];
    int   last_lat [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int id, input bit wr, input logic [7:0] a, input logic [7:0] d);
        cmd_t c;
        c = '{wr: wr, addr: a, data: d};
        if (id == 0) q0.push_back(c);
        else q1.push_back(c);
    endtask

    task automatic on_grant(input int id);
        cmd_t c;
        exp_t e;
        c = cur[id];
        chk("gnt_while_pending", act[id], 1);
        glog_id.push_back(id);
        glog_cyc.push_back(cyc);
        last_lat[id] = cyc - pres_cyc[id];
        if (c.wr) begin
            chk("wr_pins_cs_we_oe", {sram_cs, sram_we, sram_oe}, 3'b110);
            chk("wr_addr", sram_addr, c.addr);
            chk("wr_data", sram_data, c.data);
            ref_mem[c.addr] = c.data;
        end else begin
            chk("rd_pins_cs_we_oe", {sram_cs, sram_we, sram_oe}, 3'b101);
            chk("rd_addr", sram_addr, c.addr);
            e.id   = id;
            e.data = ref_mem[c.addr];
            e.due  = cyc + 2;
            sb.push_back(e);
        end
        act[id] = 1'b0;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Requester driver and per-cycle monitor share one process so grant handling precedes re-drive.
    initial begin
        exp_t e;
        bus.req_i   = '0;
        bus.we_i    = '0;
        bus.addr_i  = '0;
        bus.wdata_i = '0;
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0;
            cur[i] = '0;
        end
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                act[0] = 1'b0;
                act[1] = 1'b0;
                sb.delete();
            end else begin
                chk("oe_and_we", sram_oe && sram_we, 0);
                chk("gnt_onehot0", $onehot0(bus.gnt_o), 1);
                chk("rvalid_onehot0", $onehot0(bus.rvalid_o), 1);
                for (int id = 0; id < 2; id++)
                    if (bus.gnt_o[id]) on_grant(id);
                if (bus.rvalid_o != '0) begin
                    if (sb.size() == 0) begin
                        chk("rvalid_unexpected", {30'd0, bus.rvalid_o}, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("rv_owner", {30'd0, bus.rvalid_o}, 32'(1) << e.id);
                        chk("rv_data", bus.rdata_o, e.data);
                        chk("rv_latency", cyc, e.due);
                    end
                end
                if (!act[0] && q0.size() != 0) begin
                    cur[0] = q0.pop_front(); act[0] = 1'b1; pres_cyc[0] = cyc;
                end
                if (!act[1] && q1.size() != 0) begin
                    cur[1] = q1.pop_front(); act[1] = 1'b1; pres_cyc[1] = cyc;
                end
            end
            for (int id = 0; id < 2; id++) begin
                bus.req_i[id]            = act[id];
                bus.we_i[id]             = cur[id].wr;
                bus.addr_i[id*8 +: 8]    = cur[id].addr;
                bus.wdata_i[id*8 +: 8]   = cur[id].data;
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || act[0] || act[1] || sb.size() != 0) && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk("idle_within_budget", n < budget, 1);
        repeat (2) begin
            @(negedge clk); #1;
        end
    endtask

    initial begin
        int base;
        int n;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i) ^ 8'h3C;
            ref_mem[i] = 8'(i) ^ 8'h3C;
        end

        repeat (3) @(negedge clk);
        #1;
        chk("rst_gnt", bus.gnt_o, 0);
        chk("rst_rvalid", bus.rvalid_o, 0);
        chk("rst_pins", {sram_cs, sram_we, sram_oe}, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_rdata", bus.rdata_o, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        push(0, 1, 8'h10, 8'hA5);
        wait_idle(50);
        chk("wr_gnt_latency", last_lat[0], 1);
        chk("wr_sram_updated", mem[8'h10], 8'hA5);
        push(0, 0, 8'h10, 8'h00);
        wait_idle(50);
        chk("rd_gnt_latency", last_lat[0], 1);
        chk("rd_rdata_held", bus.rdata_o, 8'hA5);

        push(0, 1, 8'h01, 8'h11);
        wait_idle(50);
        push(1, 1, 8'h02, 8'h22);
        wait_idle(50);
        push(0, 0, 8'h01, 8'h00);
        push(1, 0, 8'h02, 8'h00);
        wait_idle(50);
        base = glog_id.size();
        chk("pair1_first", glog_id[base-2], 0);
        chk("pair1_second", glog_id[base-1], 1);
        push(0, 0, 8'h01, 8'h00);
        wait_idle(50);
        push(0, 0, 8'h01, 8'h00);
        push(1, 0, 8'h02, 8'h00);
        wait_idle(50);
        base = glog_id.size();
`ifdef SRAM_ARB_RR_EN
        chk("pair2_first", glog_id[base-2], 1);
        chk("pair2_second", glog_id[base-1], 0);
`else
        chk("pair2_first", glog_id[base-2], 0);
        chk("pair2_second", glog_id[base-1], 1);
`endif

        base = glog_cyc.size();
        for (int a = 8'hF8; a <= 8'hFF; a++) push(1, 1, 8'(a), 8'(a));
        for (int a = 8'hF8; a <= 8'hFF; a++) push(1, 0, 8'(a), 8'h00);
        wait_idle(200);
        for (int k = 1; k < 16; k++)
            chk((k <= 8) ? "b2b_wr_spacing" : "b2b_rd_spacing",
                glog_cyc[base+k] - glog_cyc[base+k-1], (k <= 8) ? 2 : 3);
        chk("b2b_last_rdata", bus.rdata_o, 8'hFF);

        push(0, 0, 8'h10, 8'h00);
        base = glog_id.size();
        n = 0;
        while (glog_id.size() == base && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        chk("rst_test_gnt_seen", glog_id.size() > base, 1);
        @(negedge clk); #1;
        chk("rst_test_in_rd_data", {sram_cs, sram_we, sram_oe}, 3'b101);
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk("midrst_gnt", bus.gnt_o, 0);
        chk("midrst_rvalid", bus.rvalid_o, 0);
        chk("midrst_pins", {sram_cs, sram_we, sram_oe}, 0);
        chk("midrst_addr", sram_addr, 0);
        chk("midrst_rdata", bus.rdata_o, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        push(1, 0, 8'h10, 8'h00);
        wait_idle(50);
        chk("post_rst_rdata", bus.rdata_o, 8'hA5);

`ifdef SRAM_ARB_RR_EN
        for (int i = 0; i < 6; i++) push(0, 0, 8'(i), 8'h00);
        base = glog_id.size();
        n = 0;
        while (glog_id.size() == base && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        push(1, 0, 8'h02, 8'h00);
        wait_idle(100);
        chk("starve_wait_bound", last_lat[1] <= 4, 1);
`endif

        for (int i = 0; i < 1000; i++)
            push($urandom_range(0, 1), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        wait_idle(8000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
